piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It accepts an N-bit word through a load/ready handshake and shifts it out one bit per enabled clock on SOUT, qualified by SVALID. A one-cycle DONE pulse marks the end of each word. It is the transmitting end for words held in the team's N-bit parallel registers, feeding a serial link or the matching serial-in/parallel-out receiver.

Parameters:
N, 8, data word width in bits (N >= 1).
MSB_FIRST, 1, 1 = transmit D[N-1] first; 0 = transmit D[0] first.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
CLR  input  1  asynchronous active-low clear.
D  input  N  parallel word to transmit.
LOAD  input  1  load request; a word is accepted on a rising edge where LOAD=1 and READY=1.
EN  input  1  shift strobe (bit-rate tick); a bit advances only on edges where EN=1.
READY  output  1  block is idle and can accept a word.
SOUT  output  1  serial data bit.
SVALID  output  1  SOUT carries a valid data bit.
DONE  output  1  one-cycle pulse after the last bit completes.

Behaviour:
- Reset: CLR=0 forces these values immediately, independent of CLK:
  - state=IDLE, shift register=0, bit count=0;
  - READY=1, SVALID=0, SOUT=0, DONE=0.
- CLR=0 in the middle of a word aborts it. No DONE is generated. After CLR returns high, the first rising edge behaves as IDLE.
- States: IDLE and SHIFT. All are registered; SOUT and SVALID are decoded from registered state only.
- IDLE:
  - READY=1, SVALID=0, SOUT=0.
  - Edge with LOAD=1: shift register <= D, count <= N-1, state <= SHIFT.
  - Edge with LOAD=0: hold.
- SHIFT:
  - READY=0, SVALID=1.
  - SOUT = shreg[N-1] when MSB_FIRST=1, else shreg[0].
  - Edge with EN=1 and count != 0: shift one place toward the output end, fill vacated bit with 0, count <= count-1.
  - Edge with EN=1 and count == 0: state <= IDLE, DONE <= 1 for exactly one cycle.
  - Edge with EN=0: hold everything.
  - LOAD is ignored in SHIFT (READY=0); D is not sampled.
- DONE: registered, high only in the first cycle after returning to IDLE. It is 0 in every other cycle.
- Latency with EN held high, word accepted at edge k:
  - bit i (i=0..N-1, in transmit order) is on SOUT between edges k+i and k+i+1;
  - DONE=1 and READY=1 between edges k+N and k+N+1.
- Back-to-back: LOAD=1 on the edge that ends the DONE cycle is accepted, giving a gap of exactly one idle cycle between words. The DONE pulse and an acceptance can coincide on the same edge.
- EN is a don't-care in IDLE. EN and LOAD high on the accept edge: the load wins and no shift occurs on that edge.
- N=1: count width = max(1, clog2(N)). A word is one bit, and DONE follows after one EN edge.
- The bit counter never wraps; SHIFT exits exactly at count 0.

Decomposition:
- Shared package: state encoding constants (IDLE=1'b0, SHIFT=1'b1) and a count-width function max(1, clog2(N)). The same package is reused by the matching receiver.
- No sub-module: the shift register, counter and two-state FSM sit in one module. The existing parallel register module is not instantiated, because its load-only behaviour does not cover shifting.

Test Plan:
- Reset: assert CLR=0 mid-cycle with no clock edge -> READY=1, SVALID=0, SOUT=0, DONE=0 immediately.
- N=8, MSB_FIRST=1, D=8'hA5, LOAD pulse, EN=1 -> SOUT sequence 1,0,1,0,0,1,0,1 with SVALID=1 for 8 cycles; DONE=1 on cycle 9 only; READY back to 1.
- EN gating: D=8'hF0, EN high only on alternate cycles -> each bit held for 2 cycles; 16 SHIFT cycles; DONE once.
- LOAD=1 with D=8'hFF during SHIFT of 8'h00 -> SOUT stays 0 for all 8 bits; the second word is not transmitted.
- CLR pulsed low after bit 3 of 8'hC3 -> immediate reset values; no DONE; a fresh LOAD of 8'h81 then transmits 1,0,0,0,0,0,0,1 cleanly.
- N=4, MSB_FIRST=0, D=4'h6, then LOAD 4'h9 held during DONE -> SOUT 0,1,1,0, one idle cycle, then 1,0,0,1; two DONE pulses.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// two-state FSM encoding and the bit-counter width helper.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter must index N-1 down to 0; a one-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a word on LOAD&READY and shifts
// it out one bit per EN tick, with SVALID qualifying SOUT and a DONE pulse after.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [N-1:0] D,
    input  logic         LOAD,
    input  logic         EN,
    output logic         READY,
    output logic         SOUT,
    output logic         SVALID,
    output logic         DONE,
    output state_t       DBG_STATE
);

    localparam int CW = cnt_width(N);

    // Handshake: a word transfers on a rising CLK edge where LOAD=1 and READY=1;
    // LOAD while READY=0 is ignored and D is not sampled.

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_shreg;
    logic [N-1:0]   w_shreg_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           w_out_bit;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // EN is irrelevant here, so a coincident EN never shifts the new word.
                if (LOAD) begin
                    w_shreg_nxt = D;
                    w_cnt_nxt   = CW'(N - 1);
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (EN) begin
                    if (r_cnt != '0) begin
                        w_shreg_nxt = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
                        w_cnt_nxt   = r_cnt - CW'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_out_bit = MSB_FIRST ? r_shreg[N-1] : r_shreg[0];

    assign READY     = (r_state == ST_IDLE);
    assign SVALID    = (r_state == ST_SHIFT);
    assign SOUT      = SVALID & w_out_bit;
    assign DONE      = r_done;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an 8-bit MSB-first and a 4-bit LSB-first instance
// driven in lockstep, compared every cycle against a word/index reference model.
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic       load;
    logic       en;
    logic [7:0] d;

    logic   a_ready, a_sout, a_svalid, a_done;
    logic   b_ready, b_sout, b_svalid, b_done;
    state_t a_state, b_state;

    piso_serializer #(.N(8), .MSB_FIRST(1'b1)) dut_a (
        .CLK(clk), .CLR(clr), .D(d), .LOAD(load), .EN(en),
        .READY(a_ready), .SOUT(a_sout), .SVALID(a_svalid), .DONE(a_done),
        .DBG_STATE(a_state)
    );

    piso_serializer #(.N(4), .MSB_FIRST(1'b0)) dut_b (
        .CLK(clk), .CLR(clr), .D(d[3:0]), .LOAD(load), .EN(en),
        .READY(b_ready), .SOUT(b_sout), .SVALID(b_svalid), .DONE(b_done),
        .DBG_STATE(b_state)
    );

    // ---------------- reference model ----------------
    // Each instance holds the accepted word and the transmit-order index of the
    // bit currently on the line; the word ends after n EN ticks.
    int         n_total = 0;
    int         n_bad   = 0;
    int         m_n[2]   = '{8, 4};
    bit         m_msb[2] = '{1'b1, 1'b0};
    logic [7:0] m_word[2];
    int         m_idx[2];
    bit         m_busy[2];
    bit         m_done[2];
    logic [0:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_sout(input int k);
        int pos;
        if (!m_busy[k]) return 1'b0;
        pos = m_msb[k] ? (m_n[k] - 1 - m_idx[k]) : m_idx[k];
        return m_word[k][pos];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_word[k] = '0;
            m_idx[k]  = 0;
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input bit ld, input bit e, input logic [7:0] dv);
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (!m_busy[k]) begin
                if (ld) begin
                    m_word[k] = (k == 1) ? (dv & 8'h0F) : dv;
                    m_idx[k]  = 0;
                    m_busy[k] = 1'b1;
                    if (k == 0)
                        for (int i = 0; i < 8; i++) exp_q.push_back(dv[7-i]);
                end
            end else if (e) begin
                m_idx[k]++;
                if (m_idx[k] == m_n[k]) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("a_ready",  32'(a_ready),  32'(!m_busy[0]));
        chk("a_svalid", 32'(a_svalid), 32'(m_busy[0]));
        chk("a_sout",   32'(a_sout),   32'(exp_sout(0)));
        chk("a_done",   32'(a_done),   32'(m_done[0]));
        chk("a_state",  32'(a_state),  32'(m_busy[0]));
        chk("b_ready",  32'(b_ready),  32'(!m_busy[1]));
        chk("b_svalid", 32'(b_svalid), 32'(m_busy[1]));
        chk("b_sout",   32'(b_sout),   32'(exp_sout(1)));
        chk("b_done",   32'(b_done),   32'(m_done[1]));
        chk("b_state",  32'(b_state),  32'(m_busy[1]));
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit ld, input bit e, input logic [7:0] dv);
        load = ld;
        en   = e;
        d    = dv;
        // Scoreboard: a bit of dut_a completes on every edge where it is valid and EN=1.
        if (a_svalid && e) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else                   chk("sb_bit", 32'(a_sout), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        model_step(ld, e, dv);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_clear();
        load = 1'b0;
        #2 clr = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        clr = 1'b1;
    endtask

    task automatic run_en(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b1, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr  = 1'b0;
        load = 1'b0;
        en   = 1'b0;
        d    = 8'h00;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        clr = 1'b1;

        // Basic word, EN held high.
        cycle(1'b1, 1'b1, 8'hA5);
        run_en(11);

        // EN on alternate cycles: every bit held for two cycles.
        cycle(1'b1, 1'b0, 8'hF0);
        for (int i = 0; i < 18; i++) cycle(1'b0, 1'(i % 2), 8'h00);
        run_en(2);

        // LOAD of 8'hFF while 8'h00 shifts is ignored.
        cycle(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 8'hFF);
        run_en(4);

        // Abort after three bits, then a clean word.
        cycle(1'b1, 1'b1, 8'hC3);
        run_en(3);
        do_clear();
        cycle(1'b1, 1'b1, 8'h81);
        run_en(11);

        // Back-to-back on the 4-bit instance: second LOAD held across the DONE cycle.
        cycle(1'b1, 1'b1, 8'h06);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'h09);
        run_en(12);

        // Randomized traffic with occasional aborts.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_clear();
            else cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                       8'($urandom_range(0, 255)));
        end
        run_en(24);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
